// File: rtl/vga_pkg.sv
// Shared VGA mode constants: per-axis timing struct, standard modes and helpers.
package vga_pkg;

  typedef struct packed {
    logic [15:0] act;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
    logic        pol;
  } vga_timing_t;

  typedef struct packed {
    vga_timing_t h;
    vga_timing_t v;
  } vga_mode_t;

  localparam vga_mode_t VGA_720X400_70 = '{
    h: '{act: 16'd720, fp: 16'd18, sync: 16'd108, bp: 16'd54, pol: 1'b0},
    v: '{act: 16'd400, fp: 16'd12, sync: 16'd2,   bp: 16'd35, pol: 1'b1}
  };

  localparam vga_mode_t VGA_640X480_60 = '{
    h: '{act: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48, pol: 1'b0},
    v: '{act: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33, pol: 1'b0}
  };

  function automatic int unsigned vga_total(input vga_timing_t t);
    return 32'(t.act) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered last/active/sync flags
// decoded from the next count, so the flags always describe the count currently held.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int          CW = 12,
  parameter vga_timing_t T  = VGA_720X400_70.h
) (
  input  logic          clock,
  input  logic          rst_i,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_wrap,
  output logic          o_active,
  output logic          o_sync
);

  localparam int unsigned    TOT      = vga_total(T);
  localparam logic [CW-1:0]  L_LAST   = CW'(TOT - 1);
  localparam logic [CW-1:0]  L_ACT    = CW'(T.act);
  localparam logic [CW-1:0]  L_SYNC_S = CW'(T.act + T.fp);
  localparam logic [CW-1:0]  L_SYNC_E = CW'(T.act + T.fp + T.sync);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_next;
  logic          r_wrap;
  logic          r_active;
  logic          r_sync;

  always_comb begin
    w_next = r_count;
    if (i_en) w_next = (r_count == L_LAST) ? '0 : r_count + 1'b1;
  end

  // o_sync is already at pin level: T.pol while in the sync region.
  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_wrap   <= 1'b0;
      r_active <= 1'b1;
      r_sync   <= ~T.pol;
    end else begin
      r_count  <= w_next;
      r_wrap   <= (w_next == L_LAST);
      r_active <= (w_next < L_ACT);
      r_sync   <= ((w_next >= L_SYNC_S) && (w_next < L_SYNC_E)) ? T.pol : ~T.pol;
    end
  end

  assign o_count  = r_count;
  assign o_wrap   = r_wrap;
  assign o_active = r_active;
  assign o_sync   = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator (sync, blanking, strobes, x/y, linear address).
// Define VGA_SCAN_DOUBLE_EN for line doubling (each source line scanned twice).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CW     = 12,
  parameter int   AW     = 19,
  parameter int   H_ACT  = int'(VGA_720X400_70.h.act),
  parameter int   H_FP   = int'(VGA_720X400_70.h.fp),
  parameter int   H_SYNC = int'(VGA_720X400_70.h.sync),
  parameter int   H_BP   = int'(VGA_720X400_70.h.bp),
  parameter int   V_ACT  = int'(VGA_720X400_70.v.act),
  parameter int   V_FP   = int'(VGA_720X400_70.v.fp),
  parameter int   V_SYNC = int'(VGA_720X400_70.v.sync),
  parameter int   V_BP   = int'(VGA_720X400_70.v.bp),
  parameter logic HS_POL = VGA_720X400_70.h.pol,
  parameter logic VS_POL = VGA_720X400_70.v.pol
) (
  input  logic          clock,
  input  logic          rst_i,
  input  logic          en,
  output logic          hs,
  output logic          vs,
  output logic          active,
  output logic          sol,
  output logic          eol,
  output logic          sof,
  output logic          eof,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [AW-1:0] pixel
);

  localparam vga_timing_t H_T = '{act: 16'(H_ACT), fp: 16'(H_FP), sync: 16'(H_SYNC),
                                  bp: 16'(H_BP), pol: HS_POL};
  localparam vga_timing_t V_T = '{act: 16'(V_ACT), fp: 16'(V_FP), sync: 16'(V_SYNC),
                                  bp: 16'(V_BP), pol: VS_POL};
  localparam logic [CW-1:0] L_VACT_M1 = CW'(V_ACT - 1);
`ifdef VGA_SCAN_DOUBLE_EN
  localparam logic [AW-1:0] L_HACT_AW = AW'(H_ACT);
`endif

  logic [CW-1:0] w_h;
  logic [CW-1:0] w_v;
  logic [CW-1:0] w_v_inc;
  logic [CW-1:0] w_v_line;
  logic [CW-1:0] w_y_nxt;
  logic [AW-1:0] w_pixel_nxt;
  logic          w_h_wrap;
  logic          w_h_act;
  logic          w_v_wrap;
  logic          w_v_act;
  logic          w_v_en;
  logic [CW-1:0] r_y;
  logic [AW-1:0] r_pixel;

  assign w_v_en = en & w_h_wrap;

  vga_axis_counter #(.CW(CW), .T(H_T)) u_h_cnt (
    .clock    (clock),
    .rst_i    (rst_i),
    .i_en     (en),
    .o_count  (w_h),
    .o_wrap   (w_h_wrap),
    .o_active (w_h_act),
    .o_sync   (hs)
  );

  vga_axis_counter #(.CW(CW), .T(V_T)) u_v_cnt (
    .clock    (clock),
    .rst_i    (rst_i),
    .i_en     (w_v_en),
    .o_count  (w_v),
    .o_wrap   (w_v_wrap),
    .o_active (w_v_act),
    .o_sync   (vs)
  );

  assign w_v_inc = w_v + 1'b1;
`ifdef VGA_SCAN_DOUBLE_EN
  assign w_v_line = w_v_inc >> 1;
`else
  assign w_v_line = w_v_inc;
`endif

  // y only moves at a line boundary, and only when the next line is visible.
  always_comb begin
    w_y_nxt = r_y;
    if (w_h_wrap) begin
      if (w_v_wrap)                w_y_nxt = '0;
      else if (w_v < L_VACT_M1)    w_y_nxt = w_v_line;
    end
  end

  always_comb begin
    w_pixel_nxt = r_pixel;
    if (w_h_wrap && w_v_wrap)      w_pixel_nxt = '0;
    else if (active)               w_pixel_nxt = r_pixel + 1'b1;
`ifdef VGA_SCAN_DOUBLE_EN
    // Leaving an even visible line: rewind so the odd line re-reads the same source.
    else if (w_h_wrap && w_v_act && !w_v[0]) w_pixel_nxt = r_pixel - L_HACT_AW;
`endif
  end

  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      r_y     <= '0;
      r_pixel <= '0;
    end else if (en) begin
      r_y     <= w_y_nxt;
      r_pixel <= w_pixel_nxt;
    end
  end

  assign active = w_h_act & w_v_act;
  assign sol    = (w_h == '0);
  assign sof    = sol & (w_v == '0);
  assign eol    = w_h_wrap;
  assign eof    = w_h_wrap & w_v_wrap;
  assign x      = active ? w_h : '0;
  assign y      = r_y;
  assign pixel  = r_pixel;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 720x400 mode, 640x480 mode, and a tiny mode for full-frame checks.
module tb_vga_timing_gen;

`ifdef VGA_SCAN_DOUBLE_EN
  localparam int E_A_Y1 = 0,    E_A_P01 = 0,    E_A_P11 = 1;
  localparam int E_A_Y2 = 1,    E_A_P300 = 1020, E_A_Y3 = 1, E_A_P03 = 720;
  localparam int E_B_P01 = 0,   E_C_P87 = 23,   E_C_Y6 = 2;
`else
  localparam int E_A_Y1 = 1,    E_A_P01 = 720,  E_A_P11 = 721;
  localparam int E_A_Y2 = 2,    E_A_P300 = 1740, E_A_Y3 = 3, E_A_P03 = 2160;
  localparam int E_B_P01 = 640, E_C_P87 = 47,   E_C_Y6 = 5;
`endif

  logic clock = 1'b0;
  logic rst_i = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;

  logic a_hs, a_vs, a_act, a_sol, a_eol, a_sof, a_eof;
  logic b_hs, b_vs, b_act, b_sol, b_eol, b_sof, b_eof;
  logic c_hs, c_vs, c_act, c_sol, c_eol, c_sof, c_eof;
  logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic [18:0] a_pix, b_pix, c_pix;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  vga_timing_gen u_dut_a (
    .clock(clock), .rst_i(rst_i), .en(en_a), .hs(a_hs), .vs(a_vs), .active(a_act),
    .sol(a_sol), .eol(a_eol), .sof(a_sof), .eof(a_eof), .x(a_x), .y(a_y), .pixel(a_pix)
  );

  vga_timing_gen #(
    .H_ACT(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACT(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_b (
    .clock(clock), .rst_i(rst_i), .en(en_b), .hs(b_hs), .vs(b_vs), .active(b_act),
    .sol(b_sol), .eol(b_eol), .sof(b_sof), .eof(b_eof), .x(b_x), .y(b_y), .pixel(b_pix)
  );

  // 16 x 10 total, 8 x 6 visible, inverted polarities
  vga_timing_gen #(
    .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0)
  ) u_dut_c (
    .clock(clock), .rst_i(rst_i), .en(en_c), .hs(c_hs), .vs(c_vs), .active(c_act),
    .sol(c_sol), .eol(c_eol), .sof(c_sof), .eof(c_eof), .x(c_x), .y(c_y), .pixel(c_pix)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int cnt, first, last, hit;
  int cnt2, first2;

  initial begin
    repeat (3) tick();
    check_val("rst_active", 32'(a_act), 1);
    check_val("rst_sol",    32'(a_sol), 1);
    check_val("rst_sof",    32'(a_sof), 1);
    check_val("rst_eol",    32'(a_eol), 0);
    check_val("rst_eof",    32'(a_eof), 0);
    check_val("rst_hs",     32'(a_hs),  1);
    check_val("rst_vs",     32'(a_vs),  0);
    check_val("rst_xy",     32'({a_x, a_y}), 0);
    check_val("rst_pixel",  32'(a_pix), 0);
    check_val("rst_c_sync", 32'({c_hs, c_vs}), 1);

    rst_i = 1'b0;
    tick();
    tick();
    check_val("hold_sof_en0", 32'(a_sof), 1);

    // Line 0 of the default mode
    en_a = 1'b1;
    cnt = 0; first = -1; last = -1;
    for (int k = 1; k <= 900; k++) begin
      tick();
      if (!a_hs) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
      if (k == 1)   check_val("a_sof_drop", 32'(a_sof), 0);
      if (k == 1)   check_val("a_pix_1",    32'(a_pix), 1);
      if (k == 719) check_val("a_x_719",    32'(a_x),   719);
      if (k == 719) check_val("a_pix_719",  32'(a_pix), 719);
      if (k == 720) check_val("a_act_720",  32'(a_act), 0);
      if (k == 720) check_val("a_x_blank",  32'(a_x),   0);
      if (k == 720) check_val("a_pix_hold", 32'(a_pix), 720);
      if (k == 899) check_val("a_eol",      32'(a_eol), 1);
      if (k == 900) check_val("a_sol_l1",   32'(a_sol), 1);
      if (k == 900) check_val("a_y_l1",     32'(a_y),   E_A_Y1);
      if (k == 900) check_val("a_pix_l1",   32'(a_pix), E_A_P01);
    end
    check_val("a_hs_width", 32'(cnt),   108);
    check_val("a_hs_first", 32'(first), 738);
    check_val("a_hs_last",  32'(last),  845);

    // en toggled every other clock across line 1
    hit = 0; cnt = 0;
    for (int c = 1; c <= 1800; c++) begin
      en_a = (c % 2 == 0);
      tick();
      if (c == 1) check_val("tog_sol_held", 32'(a_sol), 1);
      if (c == 3) check_val("tog_x_held",   32'(a_x),   1);
      if (c == 3) check_val("tog_pix_held", 32'(a_pix), E_A_P11);
      if (c > 1 && a_sol && hit == 0) hit = c;
      if (a_eol) cnt++;
    end
    check_val("tog_line_clks", 32'(hit), 1800);
    check_val("tog_eol_clks",  32'(cnt), 2);

    // Mid-frame reset at (300,2)
    en_a = 1'b1;
    repeat (300) tick();
    check_val("mid_x",     32'(a_x),   300);
    check_val("mid_y",     32'(a_y),   E_A_Y2);
    check_val("mid_pixel", 32'(a_pix), E_A_P300);
    rst_i = 1'b1;
    #1;
    check_val("async_rst_sof", 32'(a_sof), 1);
    check_val("async_rst_pix", 32'(a_pix), 0);
    check_val("async_rst_x",   32'(a_x),   0);
    repeat (3) tick();
    rst_i = 1'b0;
    #1;
    check_val("post_rst_sof", 32'(a_sof), 1);
    check_val("post_rst_pix", 32'(a_pix), 0);
    tick();
    check_val("post_rst_x1",  32'(a_x),   1);
    check_val("post_rst_p1",  32'(a_pix), 1);

    // On to (0,3)
    repeat (2699) tick();
    check_val("a_sol_l3", 32'(a_sol), 1);
    check_val("a_y_l3",   32'(a_y),   E_A_Y3);
    check_val("a_pix_l3", 32'(a_pix), E_A_P03);

    // 640x480 mode, first line
    en_a = 1'b0;
    en_b = 1'b1;
    cnt = 0; first = -1; last = -1; hit = 0; cnt2 = 0;
    for (int k = 1; k <= 801; k++) begin
      tick();
      if (!b_hs) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
      if (!b_vs) cnt2++;
      if (b_sol && hit == 0) hit = k;
      if (k == 639) check_val("b_pix_639", 32'(b_pix), 639);
      if (k == 800) check_val("b_pix_l1",  32'(b_pix), E_B_P01);
    end
    check_val("b_hs_width", 32'(cnt),   96);
    check_val("b_hs_first", 32'(first), 656);
    check_val("b_hs_last",  32'(last),  751);
    check_val("b_vs_idle",  32'(cnt2),  0);
    check_val("b_line_len", 32'(hit),   800);

    // Tiny mode, two full frames
    en_b = 1'b0;
    en_c = 1'b1;
    cnt = 0; first = -1; cnt2 = 0; first2 = 0; hit = 0; last = 0;
    for (int k = 1; k <= 320; k++) begin
      tick();
      if (k <= 160 && !c_vs) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (k <= 16 && c_hs) cnt2++;
      if (c_sof) hit++;
      if (c_eof) last++;
      if (k == 87)  check_val("c_pix_last", 32'(c_pix), E_C_P87);
      if (k == 100) check_val("c_y_blank",  32'(c_y),   E_C_Y6);
      if (k == 159) check_val("c_eof",      32'(c_eof), 1);
      if (k == 160) check_val("c_sof",      32'(c_sof), 1);
      if (k == 160) check_val("c_pix_sof",  32'(c_pix), 0);
    end
    check_val("c_vs_width", 32'(cnt),   32);
    check_val("c_vs_first", 32'(first), 112);
    check_val("c_hs_width", 32'(cnt2),  3);
    check_val("c_sof_cnt",  32'(hit),   2);
    check_val("c_eof_cnt",  32'(last),  2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
